// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: funct3 op codes,
// FSM state encoding and operand-signedness helpers.
package muldiv_sequencer_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_m_op(input logic [6:0] funct7);
    return funct7 == MD_FUNCT7;
  endfunction

  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == MD_MUL) || (f3 == MD_MULH) || (f3 == MD_MULHSU) ||
           (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == MD_MUL) || (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider datapath working on operand magnitudes,
// with sign fix-up applied as the final iteration is registered.
module muldiv_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            finish,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            special,
  output logic [XLEN-1:0] result
);
  import muldiv_sequencer_pkg::*;

  logic [2:0]        op_q;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   dvs;
  logic [2*XLEN-1:0] acc, acc_nxt, prod_fix;

  logic              sa, sb, div_zero, ovf;
  logic [XLEN-1:0]   abs_a, abs_b, spec_val, res_fix, quo, rem;
  logic [XLEN:0]     sum, rsh, diff;

  always_comb begin
    sa       = a_is_signed(funct3) & op_a[XLEN-1];
    sb       = b_is_signed(funct3) & op_b[XLEN-1];
    abs_a    = sa ? -op_a : op_a;
    abs_b    = sb ? -op_b : op_b;
    div_zero = funct3[2] && (op_b == '0);
    ovf      = ((funct3 == MD_DIV) || (funct3 == MD_REM)) &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special  = div_zero | ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (div_zero) spec_val = funct3[1] ? op_a : '1;
    else          spec_val = funct3[1] ? '0 : op_a;
  end

  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : '0);
    rsh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff = rsh - {1'b0, dvs};
    if (!op_q[2])
      acc_nxt = {sum, acc[XLEN-1:1]};
    else if (!diff[XLEN])
      acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_nxt = {rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0};

    prod_fix = neg_q ? -acc_nxt : acc_nxt;
    quo      = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem      = neg_r ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                       res_fix = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res_fix = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              res_fix = quo;
      MD_REM, MD_REMU:              res_fix = rem;
      default:                      res_fix = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dvs    <= '0;
      acc    <= '0;
      result <= '0;
    end else if (load) begin
      op_q  <= funct3;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      if (funct3[2]) begin
        dvs <= abs_b;
        acc <= {{XLEN{1'b0}}, abs_a};
      end else begin
        dvs <= abs_a;
        acc <= {{XLEN{1'b0}}, abs_b};
      end
      if (special) result <= spec_val;
    end else if (step) begin
      acc <= acc_nxt;
      if (finish) result <= res_fix;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M iterative multiply/divide sequencer: stalls EX for a fixed XLEN-cycle run
// and pulses done_out with a registered result.
//   state  | meaning
//   S_IDLE | waiting for an M-op; accepts when valid_in & ~flush
//   S_BUSY | one multiply/divide iteration per cycle, counter 0..XLEN-1
//   S_DONE | result_out valid, done_out pulses, pipeline advances
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out
);
  import muldiv_sequencer_pkg::*;

  localparam int             CW   = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]  LAST = CW'(XLEN - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          load, step, finish, special;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    stall_out = 1'b0;
    done_out  = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_in && !flush) begin
          stall_out = 1'b1;
          load      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = special ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        stall_out = 1'b1;
        if (flush) begin
          state_nxt = S_IDLE;
        end else begin
          step    = 1'b1;
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST) begin
            finish    = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        // a flushed op must not be written back
        done_out  = !flush;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  muldiv_datapath #(.XLEN(XLEN)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .finish  (finish),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .special (special),
    .result  (result_out)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall_out, done_out;
  logic [31:0] result_out;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .funct3     (funct3),
    .op_a       (op_a),
    .op_b       (op_b),
    .flush      (flush),
    .stall_out  (stall_out),
    .done_out   (done_out),
    .result_out (result_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_res = 32'h0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 1'b0;
    if (b == 32'h0) return 1'b1;
    return (f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    logic [63:0] pw;
    int          ia, ib;
    ia = signed'(a);
    ib = signed'(b);
    case (f3)
      3'b000, 3'b001: begin
        ps = longint'(ia) * longint'(ib);
        pw = 64'(ps);
        return (f3 == 3'b000) ? pw[31:0] : pw[63:32];
      end
      3'b010: begin
        ps = longint'(ia) * longint'({32'h0, b});
        pw = 64'(ps);
        return pw[63:32];
      end
      3'b011: begin
        pw = {32'h0, a} * {32'h0, b};
        return pw[63:32];
      end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every done_out pulse must match the oldest expected result and its due cycle.
  always @(negedge clk) begin
    if (done_out) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result %h expected no done_out (cycle %0d)", result_out, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", result_out, e.res);
        chk("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Issues one op (called just after a rising edge), holds valid_in through the stall.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic check_hold);
    exp_t e;
    int   st, lat;
    lat   = is_special(f3, a, b) ? 1 : 33;
    e.res = model(f3, a, b);
    e.due = cyc + lat;
    sb_q.push_back(e);
    valid_in = 1'b1;
    funct3   = f3;
    op_a     = a;
    op_b     = b;
    st = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stall_out) st++;
      else break;
    end
    chk("stall_cycles", 32'(st), 32'(lat));
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_res = e.res;
    if (check_hold) begin
      @(negedge clk);
      chk("result_hold", result_out, e.res);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", {31'b0, stall_out}, 32'h0);
    chk("reset_done", {31'b0, done_out}, 32'h0);
    chk("reset_result", result_out, 32'h0);
    @(posedge clk);
    #1;

    run_op(3'b000, 32'd7, 32'd6, 1'b1);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b1);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 1'b1);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(3'b101, 32'd100, 32'd7, 1'b1);
    run_op(3'b111, 32'd100, 32'd7, 1'b1);
    run_op(3'b101, 32'd5, 32'd0, 1'b1);
    run_op(3'b110, 32'd5, 32'd0, 1'b1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // flush in BUSY cycle 10
    valid_in = 1'b1; funct3 = 3'b000; op_a = 32'd12345; op_b = 32'd678;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_done", {31'b0, done_out}, 32'h0);
    @(posedge clk);
    #1 flush = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    chk("flush_stall", {31'b0, stall_out}, 32'h0);
    chk("flush_result", result_out, last_res);
    repeat (40) @(posedge clk);
    #1;
    run_op(3'b000, 32'd3, 32'd3, 1'b1);

    // reset in BUSY cycle 5
    valid_in = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd7;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'b0, stall_out}, 32'h0);
    chk("rst_done", {31'b0, done_out}, 32'h0);
    chk("rst_result", result_out, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    run_op(3'b101, 32'd9, 32'd3, 1'b0);
    run_op(3'b111, 32'd9, 32'd4, 1'b1);

    // flush during DONE of a special-case op suppresses done_out
    valid_in = 1'b1; funct3 = 3'b101; op_a = 32'd5; op_b = 32'd0;
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_done_pulse", {31'b0, done_out}, 32'h0);
    @(posedge clk);
    #1 flush = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    chk("flush_done_stall", {31'b0, stall_out}, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = rnd_operand();
      b  = rnd_operand();
      run_op(f3, a, b, ($urandom_range(0, 1) == 1));
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
